// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction encoder and sequential instruction-memory loader
//
// Accepts symbolic instruction descriptors on a valid/ready stream, packs each
// one into a 32-bit MIPS word, and writes the words into instruction memory
// starting at address 0. The CPU is held in reset until the image is complete.
// Optional checksum output enabled by defining IMEM_CHECKSUM_EN.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 pulse: begin a new load at address 0 (ignored while loading)
//   in_valid / in_ready   descriptor handshake
//   in_kind .. in_last    descriptor fields (kind 0=R 1=LW 2=SW 3=BEQ 4=J, 5..7 illegal)
//   imem_we/addr/wdata    instruction memory write port
//   cpu_hold              1 keeps the CPU core in reset
//   busy, done            state is LOAD / DONE
//   err                   sticky illegal-kind or overflow flag for the current load
//   count                 words written in the current load
//   chk                   (IMEM_CHECKSUM_EN only) running XOR of written words
module imem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
`ifdef IMEM_CHECKSUM_EN
   output logic [31:0]       chk,
`endif
   output logic [ADDR_W:0]   count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Count value at which the word being written lands on the last address.
   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   logic [1:0]  state;
   logic [31:0] encWord;
   logic        isLegal;
   logic        beatTaken;
   logic        startLoad;

   assign in_ready  = (state == LOAD);
   assign busy      = (state == LOAD);
   assign done      = (state == DONE);
   assign cpu_hold  = (state != DONE);
   assign beatTaken = in_valid && in_ready;
   assign startLoad = start && (state != LOAD);

   always_comb begin
      encWord = 32'h0000_0000;
      isLegal = 1'b1;
      case (in_kind)
         3'd0: encWord = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
         3'd1: encWord = {6'b100011, in_rs, in_rt, in_imm};
         3'd2: encWord = {6'b101011, in_rs, in_rt, in_imm};
         3'd3: encWord = {6'b000100, in_rs, in_rt, in_imm};
         3'd4: encWord = {6'b000010, in_target};
         default: isLegal = 1'b0;
      endcase
   end

   // count doubles as the write pointer: its low bits are the next address.
   // Overflow ends the load at DEPTH words, so count never passes DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         err        <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0000_0000;
`ifdef IMEM_CHECKSUM_EN
         chk        <= 32'h0000_0000;
`endif
      end else begin
         imem_we <= 1'b0;
         if (startLoad) begin
            state <= LOAD;
            count <= '0;
            err   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            chk   <= 32'h0000_0000;
`endif
         end else if (beatTaken) begin
            if (isLegal) begin
               imem_we    <= 1'b1;
               imem_addr  <= count[ADDR_W-1:0];
               imem_wdata <= encWord;
               count      <= count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
               chk        <= chk ^ encWord;
`endif
               if (in_last) begin
                  state <= DONE;
               end else if (count == LAST_CNT) begin
                  state <= DONE;
                  err   <= 1'b1;
               end
            end else begin
               // Illegal descriptor is consumed without a write.
               err <= 1'b1;
               if (in_last) begin
                  state <= DONE;
               end
            end
         end else if (state != IDLE && state != LOAD && state != DONE) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_kind;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [6:0]  count;
`ifdef IMEM_CHECKSUM_EN
   logic [31:0] chk;
`endif

   int checks = 0;
   int errors = 0;

   imem_loader #(.ADDR_W(6)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
      .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
`ifdef IMEM_CHECKSUM_EN
      .chk(chk),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
      in_valid  = 1'b1;
      in_kind   = k;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_funct  = fn;
      in_imm    = imm;
      in_target = tgt;
      in_last   = last;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_kind = 3'd0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
      in_target = '0; in_last = 1'b0;
      tick();
      tick();
      check("rst_hold", {31'b0, cpu_hold}, 32'd1);
      check("rst_ready", {31'b0, in_ready}, 32'd0);
      check("rst_we", {31'b0, imem_we}, 32'd0);
      check("rst_addr", {26'b0, imem_addr}, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_count", {25'b0, count}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);
      beat(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      tick();
      check("idle_no_accept_we", {31'b0, imem_we}, 32'd0);
      check("idle_no_accept_cnt", {25'b0, count}, 32'd0);
      in_valid = 1'b0;

      // Five back-to-back beats, one of each kind.
      pulse_start();
      check("load_ready", {31'b0, in_ready}, 32'd1);
      check("load_hold", {31'b0, cpu_hold}, 32'd1);
      beat(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
      tick();
      check("r_we", {31'b0, imem_we}, 32'd1);
      check("r_addr", {26'b0, imem_addr}, 32'd0);
      check("r_data", imem_wdata, 32'h0022_1820);
      check("r_count", {25'b0, count}, 32'd1);
      beat(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      tick();
      check("lw_addr", {26'b0, imem_addr}, 32'd1);
      check("lw_data", imem_wdata, 32'h8C22_0004);
      beat(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0);
      tick();
      check("sw_addr", {26'b0, imem_addr}, 32'd2);
      check("sw_data", imem_wdata, 32'hAC22_0008);
      beat(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
      tick();
      check("beq_addr", {26'b0, imem_addr}, 32'd3);
      check("beq_data", imem_wdata, 32'h1022_FFFF);
      check("beq_done", {31'b0, done}, 32'd0);
      beat(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
      tick();
      check("j_we", {31'b0, imem_we}, 32'd1);
      check("j_addr", {26'b0, imem_addr}, 32'd4);
      check("j_data", imem_wdata, 32'h0800_0010);
      check("j_done", {31'b0, done}, 32'd1);
      check("j_hold", {31'b0, cpu_hold}, 32'd0);
      check("j_count", {25'b0, count}, 32'd5);
      check("j_err", {31'b0, err}, 32'd0);
      in_valid = 1'b0;
      tick();
      check("done_we_low", {31'b0, imem_we}, 32'd0);
      check("done_ready", {31'b0, in_ready}, 32'd0);
      check("done_hold_data", imem_wdata, 32'h0800_0010);

      // Illegal kind between two lw beats, with idle gaps.
      pulse_start();
      check("reload_hold", {31'b0, cpu_hold}, 32'd1);
      check("reload_count", {25'b0, count}, 32'd0);
      beat(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      tick();
      check("il_w0_addr", {26'b0, imem_addr}, 32'd0);
      in_valid = 1'b0;
      tick();
      check("il_gap_we", {31'b0, imem_we}, 32'd0);
      check("il_gap_err", {31'b0, err}, 32'd0);
      beat(3'd6, 5'd1, 5'd2, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      tick();
      check("il_we", {31'b0, imem_we}, 32'd0);
      check("il_err", {31'b0, err}, 32'd1);
      check("il_count", {25'b0, count}, 32'd1);
      in_valid = 1'b0;
      tick();
      beat(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd8, 26'd0, 1'b1);
      tick();
      check("il_w1_addr", {26'b0, imem_addr}, 32'd1);
      check("il_w1_data", imem_wdata, 32'h8C22_0008);
      check("il_count2", {25'b0, count}, 32'd2);
      check("il_err_sticky", {31'b0, err}, 32'd1);
      check("il_done", {31'b0, done}, 32'd1);
      in_valid = 1'b0;

      // Overflow: 64 beats without in_last.
      pulse_start();
      check("ov_err_cleared", {31'b0, err}, 32'd0);
      for (int i = 0; i < 64; i++) begin
         beat(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i), 1'b0);
         tick();
         if (i == 62) begin
            check("ov_62_done", {31'b0, done}, 32'd0);
            check("ov_62_addr", {26'b0, imem_addr}, 32'd62);
         end
      end
      check("ov_addr", {26'b0, imem_addr}, 32'd63);
      check("ov_data", imem_wdata, 32'h0800_003F);
      check("ov_done", {31'b0, done}, 32'd1);
      check("ov_err", {31'b0, err}, 32'd1);
      check("ov_count", {25'b0, count}, 32'd64);
      check("ov_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("ov_no_more_we", {31'b0, imem_we}, 32'd0);
      check("ov_count_sat", {25'b0, count}, 32'd64);
      in_valid = 1'b0;

      // Reset in the middle of a load.
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         beat(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i + 1), 1'b0);
         tick();
      end
      check("mid_count", {25'b0, count}, 32'd4);
      reset = 1'b1;
      tick();
      check("mid_rst_count", {25'b0, count}, 32'd0);
      check("mid_rst_hold", {31'b0, cpu_hold}, 32'd1);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_we", {31'b0, imem_we}, 32'd0);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      pulse_start();
      beat(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b1);
      tick();
      check("post_rst_addr", {26'b0, imem_addr}, 32'd0);
      check("post_rst_data", imem_wdata, 32'h0022_1820);
      check("post_rst_count", {25'b0, count}, 32'd1);
      in_valid = 1'b0;

`ifdef IMEM_CHECKSUM_EN
      pulse_start();
      check("chk_clear0", chk, 32'd0);
      beat(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
      tick();
      check("chk_first", chk, 32'h0022_1820);
      beat(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
      tick();
      check("chk_final", chk, 32'h8C00_1824);
      in_valid = 1'b0;
      tick();
      check("chk_stable", chk, 32'h8C00_1824);
      pulse_start();
      check("chk_restart", chk, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
